nbit_alu_seq: RTL and testbench

//   Registered, handshaked N-bit ALU; the sequential successor to the combinational Nbit_ALU.

---
 rtl/nbit_alu_seq.sv | 85 ++++++++
 tb/tb_nbit_alu_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_alu_seq.sv
// nbit_alu_seq: registered valid/ready ALU with {V,C,Z} flags and a bit-serial shift-left
module nbit_alu_seq #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   ALUop,
    input  logic [n-1:0] r2,
    input  logic [n-1:0] r3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] r1,
    output logic [2:0]   flags
);
    localparam int SHW = $clog2(n);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t state_q, state_d;
    logic [n-1:0] r1_q, r1_d, b_eff, res;
    logic [2:0] flags_q, flags_d;
    logic [SHW-1:0] cnt_q, cnt_d, shamt;
    logic [n:0] sum;
    logic accept, is_add, ovf, c_res, shl_start;
    assign shamt = r3[SHW-1:0];
    assign is_add = ALUop == 3'b010;
    assign b_eff = is_add ? r3 : ~r3;
    assign sum = {1'b0, r2} + {1'b0, b_eff} + {{n{1'b0}}, ~is_add};
    assign ovf = (r2[n-1] == b_eff[n-1]) && (sum[n-1] != r2[n-1]);
    assign shl_start = ALUop == 3'b111 && shamt != '0;
    assign in_ready = !rst && (state_q == IDLE || (state_q == HOLD && out_ready));
    assign accept = in_valid && in_ready;
    assign out_valid = state_q == HOLD;
    assign r1 = r1_q;
    assign flags = flags_q;
    always_comb begin
        res = '0;
        c_res = 1'b0;
        case (ALUop)
            3'b000: res = r2 & r3;
            3'b001: res = r2 | r3;
            3'b010, 3'b011: {c_res, res} = sum;
            3'b100: res = r2 ^ r3;
            3'b101: res = ~(r2 | r3);
            3'b110: res = {{(n-1){1'b0}}, sum[n-1] ^ ovf};
            default: res = r2;
        endcase
    end
    always_comb begin
        state_d = state_q;
        r1_d = r1_q;
        flags_d = flags_q;
        cnt_d = cnt_q;
        if (accept && shl_start) begin
            state_d = BUSY;
            r1_d = r2;
            cnt_d = shamt;
            flags_d = '0;
        end else if (accept) begin
            state_d = HOLD;
            r1_d = res;
            flags_d = {ALUop[2:1] == 2'b01 && ovf, c_res, res == '0};
        end else if (state_q == BUSY) begin
            r1_d = r1_q << 1;
            flags_d = {1'b0, r1_q[n-1], r1_q[n-2:0] == '0};
            cnt_d = cnt_q - 1'b1;
            state_d = (cnt_q == SHW'(1)) ? HOLD : BUSY;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r1_q <= '0;
            flags_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            r1_q <= r1_d;
            flags_q <= flags_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_nbit_alu_seq.sv
// tb_nbit_alu_seq: scoreboard bench for nbit_alu_seq at n=32 plus a small n=8 instance
module tb_nbit_alu_seq;
    typedef struct packed { logic [31:0] r; logic [2:0] f; } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
    logic [2:0] ALUop = '0, flags;
    logic [31:0] r2 = '0, r3 = '0, r1;
    logic in_valid8 = 1'b0, in_ready8, out_valid8;
    logic [2:0] ALUop8 = '0, flags8;
    logic [7:0] r2_8 = '0, r3_8 = '0, r1_8;
    exp_t sbq[$];
    exp_t got_e;
    int n_run = 0, n_fail = 0;
    always #5 clk = ~clk;
    nbit_alu_seq #(.n(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUop(ALUop),
        .r2(r2), .r3(r3), .out_valid(out_valid), .out_ready(out_ready), .r1(r1), .flags(flags)
    );
    nbit_alu_seq #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .ALUop(ALUop8),
        .r2(r2_8), .r3(r3_8), .out_valid(out_valid8), .out_ready(1'b1), .r1(r1_8), .flags(flags8)
    );
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        longint s;
        logic [32:0] w;
        int k;
        e = '0;
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: begin
                w = {1'b0, a} + {1'b0, b};
                e.r = w[31:0];
                e.f[1] = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                e.f[2] = s != longint'($signed(e.r));
            end
            3'd3: begin
                e.r = a - b;
                e.f[1] = a >= b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.f[2] = s != longint'($signed(e.r));
            end
            3'd4: e.r = a ^ b;
            3'd5: e.r = ~(a | b);
            3'd6: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                k = int'(b[4:0]);
                e.r = a << k;
                e.f[1] = (k == 0) ? 1'b0 : a[32-k];
            end
        endcase
        e.f[0] = e.r == 32'd0;
        return e;
    endfunction
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) check("sb_unexpected", out_valid, 0);
            else begin
                got_e = sbq.pop_front();
                check("r1", r1, got_e.r);
                check("flags", flags, got_e.f);
            end
        end
    end
    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int t = 0;
        sbq.push_back(model(op, a, b));
        ALUop = op;
        r2 = a;
        r3 = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", t < 100, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        r2 = $urandom;
        r3 = $urandom;
        ALUop = 3'($urandom);
    endtask
    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_r1", r1, 0);
        check("rst_flags", flags, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        // n=8: ADD overflow and the maximum shift
        @(posedge clk);
        #1 ALUop8 = 3'd2;
        r2_8 = 8'h7F;
        r3_8 = 8'h01;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        @(negedge clk);
        check("add8_valid", out_valid8, 1);
        check("add8_r1", r1_8, 8'h80);
        check("add8_flags", flags8, 3'b100);
        @(posedge clk);
        #1 ALUop8 = 3'd7;
        r2_8 = 8'h01;
        r3_8 = 8'h07;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("shl8_busy", out_valid8, 0);
        end
        @(negedge clk);
        check("shl8_valid", out_valid8, 1);
        check("shl8_r1", r1_8, 8'h80);
        check("shl8_flags", flags8, 3'b000);
        @(posedge clk);
        #1;
        // ADD wrap, SUB overflow, SLT
        issue(3'd2, 32'hFFFF_FFFF, 32'h1);
        issue(3'd3, 32'h8000_0000, 32'h1);
        issue(3'd6, 32'h8000_0000, 32'h1);
        issue(3'd6, 32'h1, 32'h8000_0000);
        issue(3'd2, 32'h7FFF_FFFF, 32'h1);
        issue(3'd3, 32'h1234_5678, 32'h1234_5678);
        issue(3'd5, 32'h0, 32'h0);
        drain();
        // multi-cycle shift timing
        issue(3'd7, 32'h8000_0001, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("shl_busy_ready", in_ready, 0);
            check("shl_busy_valid", out_valid, 0);
        end
        @(negedge clk);
        check("shl_done_valid", out_valid, 1);
        drain();
        issue(3'd7, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("shl0_latency", out_valid, 1);
        drain();
        issue(3'd7, 32'hC000_0001, 32'd31);
        drain();
        // backpressure, then back-to-back accept
        out_ready = 1'b0;
        issue(3'd2, 32'd5, 32'd7);
        sbq.push_back(model(3'd3, 32'd100, 32'd58));
        ALUop = 3'd3;
        r2 = 32'd100;
        r3 = 32'd58;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_r1", r1, 32'd12);
            check("bp_flags", flags, 3'b000);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        drain();
        // reset mid-shift
        ALUop = 3'd7;
        r2 = 32'hFFFF_FFFF;
        r3 = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_pre_rst", out_valid, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_r1", r1, 0);
        check("abort_flags", flags, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        issue(3'd0, 32'h0000_F0F0, 32'h0000_FF00);
        drain();
        // random mix
        for (int i = 0; i < 40; i++) issue(3'($urandom), $urandom, $urandom);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
